// File: rtl/seq_check_mon.sv
`default_nettype none
// ============================================================================
// Module      : seq_check_mon
// Description : Hardware monitor for the rule
//                 "a high => b high on B_COUNT later cycles (not necessarily
//                  consecutive) => c high on the cycle after the last b".
//               Up to NSLOT overlapping attempts are tracked. Each attempt
//               resolves into a one-cycle pass or fail pulse on its slot bit,
//               and saturating totals of both outcomes are kept.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : NSLOT   - concurrently tracked attempts (1..8)
//               B_COUNT - b occurrences required (1..7)
//               TIMEOUT - max edges an attempt may spend counting; only
//                         active when SEQ_CHECK_MON_TIMEOUT_EN is defined
// Macro       : SEQ_CHECK_MON_TIMEOUT_EN - enables per-slot age/timeout
// Ports       : clk      in   clock, all sampling on posedge
//               rst      in   synchronous active-high reset
//               a        in   attempt trigger
//               b        in   counted event
//               c        in   consequent
//               pass     out  [NSLOT] one-cycle per-slot pass pulse
//               fail     out  [NSLOT] one-cycle per-slot fail pulse
//               overflow out  one-cycle pulse, a seen with no free slot
//               busy     out  any slot not idle
//               pass_cnt out  [16] saturating pass total
//               fail_cnt out  [16] saturating fail total (incl. timeouts)
// ============================================================================
module seq_check_mon #(
    parameter int NSLOT   = 4,
    parameter int B_COUNT = 5,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic [NSLOT-1:0] pass,
    output logic [NSLOT-1:0] fail,
    output logic             overflow,
    output logic             busy,
    output logic [15:0]      pass_cnt,
    output logic [15:0]      fail_cnt
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_count = 2'd1;
    localparam logic [1:0] c_st_check = 2'd2;
    localparam logic [2:0] c_b_last   = 3'(B_COUNT);

    logic [1:0]       r_state    [NSLOT];
    logic [2:0]       r_cnt      [NSLOT];
    logic [1:0]       w_state_nx [NSLOT];
    logic [2:0]       w_cnt_nx   [NSLOT];
    logic [NSLOT-1:0] w_grant;
    logic [NSLOT-1:0] w_pass_nx;
    logic [NSLOT-1:0] w_fail_nx;
    logic             w_free_found;
    logic             w_overflow_nx;
    logic             w_busy_nx;
    logic [16:0]      w_pass_sum;
    logic [16:0]      w_fail_sum;

`ifdef SEQ_CHECK_MON_TIMEOUT_EN
    localparam int                 c_age_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_age_w-1:0] c_age_last = c_age_w'(TIMEOUT - 1);

    logic [c_age_w-1:0] r_age    [NSLOT];
    logic [c_age_w-1:0] w_age_nx [NSLOT];
`else
    // Without the timeout build TIMEOUT shapes no logic; this guard keeps it
    // referenced and elaborates nothing for any legal setting.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    // Next-state for every slot. Allocation looks only at the slots idle at
    // this edge, so a slot resolving now becomes allocatable one edge later.
    always_comb begin
        w_free_found = 1'b0;
        w_grant      = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (!w_free_found && (r_state[i] == c_st_idle)) begin
                w_grant[i]   = a;
                w_free_found = 1'b1;
            end
        end
        w_overflow_nx = a && !w_free_found;

        w_pass_nx = '0;
        w_fail_nx = '0;
        w_busy_nx = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            w_state_nx[i] = r_state[i];
            w_cnt_nx[i]   = r_cnt[i];
`ifdef SEQ_CHECK_MON_TIMEOUT_EN
            w_age_nx[i]   = r_age[i];
`endif
            case (r_state[i])
                c_st_idle: begin
                    // The b sampled at the allocating edge is not counted.
                    if (w_grant[i]) begin
                        w_state_nx[i] = c_st_count;
                        w_cnt_nx[i]   = 3'd0;
`ifdef SEQ_CHECK_MON_TIMEOUT_EN
                        w_age_nx[i]   = '0;
`endif
                    end
                end
                c_st_count: begin
                    if (b) begin
                        w_cnt_nx[i] = r_cnt[i] + 3'd1;
                    end
                    // Completing the count beats a timeout on the same edge.
                    if (b && ((r_cnt[i] + 3'd1) == c_b_last)) begin
                        w_state_nx[i] = c_st_check;
                    end
`ifdef SEQ_CHECK_MON_TIMEOUT_EN
                    else if (r_age[i] == c_age_last) begin
                        w_state_nx[i] = c_st_idle;
                        w_fail_nx[i]  = 1'b1;
                    end
                    w_age_nx[i] = r_age[i] + 1'b1;
`endif
                end
                c_st_check: begin
                    w_pass_nx[i]  = c;
                    w_fail_nx[i]  = !c;
                    w_state_nx[i] = c_st_idle;
                end
                default: begin
                    w_state_nx[i] = c_st_idle;
                end
            endcase
            w_busy_nx = w_busy_nx | (w_state_nx[i] != c_st_idle);
        end

        // Totals absorb the pulses currently on the outputs; 17 bits leave
        // room for the carry that triggers saturation.
        w_pass_sum = {1'b0, pass_cnt};
        w_fail_sum = {1'b0, fail_cnt};
        for (int i = 0; i < NSLOT; i++) begin
            w_pass_sum = w_pass_sum + {16'd0, pass[i]};
            w_fail_sum = w_fail_sum + {16'd0, fail[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSLOT; i++) begin
                r_state[i] <= c_st_idle;
                r_cnt[i]   <= 3'd0;
`ifdef SEQ_CHECK_MON_TIMEOUT_EN
                r_age[i]   <= '0;
`endif
            end
            pass     <= '0;
            fail     <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            pass_cnt <= 16'd0;
            fail_cnt <= 16'd0;
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                r_state[i] <= w_state_nx[i];
                r_cnt[i]   <= w_cnt_nx[i];
`ifdef SEQ_CHECK_MON_TIMEOUT_EN
                r_age[i]   <= w_age_nx[i];
`endif
            end
            pass     <= w_pass_nx;
            fail     <= w_fail_nx;
            overflow <= w_overflow_nx;
            busy     <= w_busy_nx;
            pass_cnt <= w_pass_sum[16] ? 16'hFFFF : w_pass_sum[15:0];
            fail_cnt <= w_fail_sum[16] ? 16'hFFFF : w_fail_sum[15:0];
        end
    end

endmodule
`default_nettype wire
